// File: rtl/fpu_pkg.sv
// Shared FP issue definitions: funct7/funct3 encodings, FPU op select and
// per-op latencies used by the issue scoreboard.
package fpu_pkg;

  localparam int TAGW_DEF = 5;
  localparam int LAT_ADD  = 2;
  localparam int LAT_MUL  = 2;
  localparam int LAT_DIV  = 8;
  localparam int LAT_CVT  = 1;
  localparam int LAT_CMP  = 1;
  localparam int MAXLAT   = 16;
  localparam int LATW     = $clog2(MAXLAT);
  localparam int DCW      = $clog2(LAT_DIV);

  localparam logic [6:0] F7_FADD   = 7'b0000000;
  localparam logic [6:0] F7_FSUB   = 7'b0000100;
  localparam logic [6:0] F7_FMUL   = 7'b0001000;
  localparam logic [6:0] F7_FDIV   = 7'b0001100;
  localparam logic [6:0] F7_FSQRT  = 7'b0101100;
  localparam logic [6:0] F7_FCMP   = 7'b1010000;
  localparam logic [6:0] F7_FCVTWS = 7'b1100000;
  localparam logic [6:0] F7_FCVTSW = 7'b1101000;

  localparam logic [2:0] F3_FEQ = 3'b010;
  localparam logic [2:0] F3_FLT = 3'b001;
  localparam logic [2:0] F3_FLE = 3'b000;

  typedef enum logic [3:0] {
    FPU_ADD   = 4'd0,
    FPU_SUB   = 4'd1,
    FPU_MUL   = 4'd2,
    FPU_DIV   = 4'd3,
    FPU_SQRT  = 4'd4,
    FPU_CVTWS = 4'd5,
    FPU_FEQ   = 4'd6,
    FPU_FLT   = 4'd7,
    FPU_FLE   = 4'd8,
    FPU_CVTSW = 4'd9
  } fpuctl_e;

  typedef logic [LATW-1:0] lat_t;

  function automatic lat_t op_latency(fpuctl_e op);
    case (op)
      FPU_ADD, FPU_SUB:     return lat_t'(LAT_ADD);
      FPU_MUL:              return lat_t'(LAT_MUL);
      FPU_DIV, FPU_SQRT:    return lat_t'(LAT_DIV);
      FPU_CVTWS, FPU_CVTSW: return lat_t'(LAT_CVT);
      default:              return lat_t'(LAT_CMP);
    endcase
  endfunction

endpackage

// File: rtl/fpu_op_decode.sv
// Combinational FP instruction decode: funct7/funct3 to FPU op select,
// operand-source and mode flags, plus illegal and divider-use indications.
module fpu_op_decode
  import fpu_pkg::*;
(
  input  logic [6:0] funct7_i,
  input  logic [2:0] funct3_i,
  output fpuctl_e    ctl_o,
  output logic       srca_o,
  output logic       mode_o,
  output logic       illegal_o,
  output logic       is_div_o
);

  always_comb begin
    ctl_o     = FPU_ADD;
    srca_o    = 1'b0;
    mode_o    = 1'b0;
    illegal_o = 1'b0;
    is_div_o  = 1'b0;
    case (funct7_i)
      F7_FADD:  ctl_o = FPU_ADD;
      F7_FSUB:  ctl_o = FPU_SUB;
      F7_FMUL:  ctl_o = FPU_MUL;
      F7_FDIV: begin
        ctl_o    = FPU_DIV;
        is_div_o = 1'b1;
      end
      F7_FSQRT: begin
        ctl_o    = FPU_SQRT;
        is_div_o = 1'b1;
      end
      F7_FCVTWS: begin
        ctl_o  = FPU_CVTWS;
        mode_o = (funct3_i == 3'b010);
      end
      F7_FCVTSW: begin
        ctl_o  = FPU_CVTSW;
        srca_o = 1'b1;
      end
      F7_FCMP: begin
        case (funct3_i)
          F3_FEQ:  ctl_o = FPU_FEQ;
          F3_FLT:  ctl_o = FPU_FLT;
          F3_FLE:  ctl_o = FPU_FLE;
          default: illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FP issue control: decodes the op, stalls on writeback-slot or divider
// conflicts, and tracks in-flight results so exactly one writes back per cycle.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int TAGW = TAGW_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [TAGW-1:0] rd,
  output logic            fpu_valid,
  output logic [3:0]      fpucontrol,
  output logic            fpusrca,
  output logic            mode,
  output logic            illegal,
  output logic            wb_valid,
  output logic [TAGW-1:0] wb_rd,
  output logic            busy
);

  fpuctl_e dec_ctl;
  logic    dec_illegal;
  logic    dec_is_div;
  lat_t    lat;
  lat_t    lat_m1;
  logic    accept;
  logic    accept_legal;

  logic [MAXLAT-1:0] slot_q, slot_d;
  logic [TAGW-1:0]   tag_q [MAXLAT];
  logic [TAGW-1:0]   tag_d [MAXLAT];
  logic [DCW-1:0]    divcnt_q, divcnt_d;

  fpu_op_decode u_decode (
    .funct7_i  (funct7),
    .funct3_i  (funct3),
    .ctl_o     (dec_ctl),
    .srca_o    (fpusrca),
    .mode_o    (mode),
    .illegal_o (dec_illegal),
    .is_div_o  (dec_is_div)
  );

  assign lat    = op_latency(dec_ctl);
  assign lat_m1 = lat - LATW'(1);

  // slot_q[lat] shifts into slot[lat-1] at this edge, so it is the one to test.
  always_comb begin
    in_ready = 1'b0;
    if (!flush) begin
      if (dec_illegal) in_ready = 1'b1;
      else             in_ready = !slot_q[lat] && !(dec_is_div && (divcnt_q != '0));
    end
  end

  assign accept       = in_valid && in_ready;
  assign accept_legal = accept && !dec_illegal;

  assign fpu_valid  = accept;
  assign fpucontrol = dec_ctl;
  assign illegal    = accept && dec_illegal;

  always_comb begin
    slot_d = {1'b0, slot_q[MAXLAT-1:1]};
    for (int i = 0; i < MAXLAT - 1; i++) tag_d[i] = tag_q[i+1];
    tag_d[MAXLAT-1] = tag_q[MAXLAT-1];
    divcnt_d = (divcnt_q != '0) ? divcnt_q - DCW'(1) : '0;
    if (flush) begin
      slot_d   = '0;
      divcnt_d = '0;
    end else if (accept_legal) begin
      slot_d[lat_m1] = 1'b1;
      tag_d[lat_m1]  = rd;
      if (dec_is_div) divcnt_d = DCW'(LAT_DIV - 1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_q   <= '0;
      divcnt_q <= '0;
      for (int i = 0; i < MAXLAT; i++) tag_q[i] <= '0;
    end else begin
      slot_q   <= slot_d;
      divcnt_q <= divcnt_d;
      for (int i = 0; i < MAXLAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign wb_valid = slot_q[0];
  assign wb_rd    = tag_q[0];
  assign busy     = (|slot_q) || (divcnt_q != '0);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: decode vector table, hand-written multi-cycle
// sequences, then random traffic against a due-cycle scoreboard model.
module tb_fpu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic [4:0] rd = '0;
  logic       fpu_valid;
  logic [3:0] fpucontrol;
  logic       fpusrca, mode, illegal, wb_valid, busy;
  logic [4:0] wb_rd;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.TAGW(5)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .funct7(funct7), .rd(rd), .fpu_valid(fpu_valid),
    .fpucontrol(fpucontrol), .fpusrca(fpusrca), .mode(mode), .illegal(illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .busy(busy)
  );

  typedef struct {
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] ctl;
    logic       srca;
    logic       md;
    logic       ill;
    int         lat;
  } vec_t;

  typedef struct {
    int         due;
    logic [4:0] rd;
  } pend_t;

  vec_t  vecs[13];
  pend_t pq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] r,
                       input logic v);
    funct7 = f7; funct3 = f3; rd = r; in_valid = v;
  endtask

  // Reference decode from the ISA encodings: op select, latency, flags.
  function automatic void ref_decode(input logic [6:0] f7, input logic [2:0] f3,
                                     output int ctl, output int lat, output bit ill,
                                     output bit dv);
    ctl = 0; lat = 2; ill = 1'b0; dv = 1'b0;
    case (f7)
      7'h00: begin ctl = 0; lat = 2; end
      7'h04: begin ctl = 1; lat = 2; end
      7'h08: begin ctl = 2; lat = 2; end
      7'h0C: begin ctl = 3; lat = 8; dv = 1'b1; end
      7'h2C: begin ctl = 4; lat = 8; dv = 1'b1; end
      7'h60: begin ctl = 5; lat = 1; end
      7'h68: begin ctl = 9; lat = 1; end
      7'h50: begin
        lat = 1;
        if (f3 == 3'd2)      ctl = 6;
        else if (f3 == 3'd1) ctl = 7;
        else if (f3 == 3'd0) ctl = 8;
        else begin ctl = 0; ill = 1'b1; end
      end
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic run_vec(input vec_t v, input logic [4:0] r);
    int hit;
    int hits;
    logic [4:0] got;
    hit = -1; hits = 0; got = '0;
    drive(v.f7, v.f3, r, 1'b1);
    #3;
    chk("vec_ready", in_ready, 1);
    chk("vec_fpu_valid", fpu_valid, 1);
    chk("vec_ctl", fpucontrol, v.ctl);
    chk("vec_srca", fpusrca, v.srca);
    chk("vec_mode", mode, v.md);
    chk("vec_illegal", illegal, v.ill);
    step();
    drive(7'h00, 3'd0, 5'd0, 1'b0);
    for (int c = 1; c <= 18; c++) begin
      #3;
      if (wb_valid) begin
        hits++;
        if (hit < 0) begin hit = c; got = wb_rd; end
      end
      step();
    end
    chk("vec_wb_count", hits, v.ill ? 0 : 1);
    if (!v.ill) begin
      chk("vec_wb_cycle", hit, v.lat);
      chk("vec_wb_rd", got, r);
    end
    $display("vec f7=%h f3=%0d ctl=%0d wb_hits=%0d wb_cycle=%0d", v.f7, v.f3, v.ctl, hits, hit);
  endtask

  initial begin
    logic [6:0] f7list[9];
    int         t, div_free, ectl, elat, exp_wb;
    bit         eill, edv, eready, eacc, ebusy;
    logic [4:0] exp_rd;

    f7list = '{7'h00, 7'h04, 7'h08, 7'h0C, 7'h2C, 7'h60, 7'h68, 7'h50, 7'h7F};
    vecs[0]  = '{7'h00, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2};
    vecs[1]  = '{7'h04, 3'd0, 4'd1, 1'b0, 1'b0, 1'b0, 2};
    vecs[2]  = '{7'h08, 3'd0, 4'd2, 1'b0, 1'b0, 1'b0, 2};
    vecs[3]  = '{7'h0C, 3'd0, 4'd3, 1'b0, 1'b0, 1'b0, 8};
    vecs[4]  = '{7'h2C, 3'd0, 4'd4, 1'b0, 1'b0, 1'b0, 8};
    vecs[5]  = '{7'h60, 3'd2, 4'd5, 1'b0, 1'b1, 1'b0, 1};
    vecs[6]  = '{7'h60, 3'd1, 4'd5, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{7'h68, 3'd0, 4'd9, 1'b1, 1'b0, 1'b0, 1};
    vecs[8]  = '{7'h50, 3'd2, 4'd6, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{7'h50, 3'd1, 4'd7, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{7'h50, 3'd0, 4'd8, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{7'h7F, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1, 0};
    vecs[12] = '{7'h50, 3'd3, 4'd0, 1'b0, 1'b0, 1'b1, 0};

    // Reset state
    step();
    #3;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_busy", busy, 0);
    step();
    rstn = 1'b1;
    #3;
    chk("idle_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    step();

    foreach (vecs[i]) run_vec(vecs[i], 5'(i + 3));

    // ADD then compare: compare collides at the same writeback slot
    drive(7'h00, 3'd0, 5'd1, 1'b1); #3;
    chk("t2_add_accept", fpu_valid, 1); step();
    drive(7'h50, 3'd2, 5'd2, 1'b1); #3;
    chk("t2_feq_stall", in_ready, 0);
    chk("t2_feq_no_launch", fpu_valid, 0); step();
    #3;
    chk("t2_feq_ready", in_ready, 1);
    chk("t2_feq_ctl", fpucontrol, 6);
    chk("t2_wb1_valid", wb_valid, 1);
    chk("t2_wb1_rd", wb_rd, 1); step();
    in_valid = 1'b0; #3;
    chk("t2_wb2_valid", wb_valid, 1);
    chk("t2_wb2_rd", wb_rd, 2); step();
    #3; chk("t2_wb_idle", wb_valid, 0); step();
    $display("seq add/feq collision done");

    // Divider is non-pipelined; a MUL may overlap it
    drive(7'h0C, 3'd0, 5'd4, 1'b1); #3;
    chk("t3_div_accept", fpu_valid, 1); step();
    for (int c = 1; c <= 17; c++) begin
      if (c == 1)                drive(7'h08, 3'd0, 5'd6, 1'b1);
      else if (c >= 2 && c <= 8) drive(7'h2C, 3'd0, 5'd5, 1'b1);
      else                       drive(7'h00, 3'd0, 5'd0, 1'b0);
      #3;
      if (c == 1)                chk("t3_mul_ready", in_ready, 1);
      else if (c >= 2 && c <= 7) chk("t3_sqrt_stall", in_ready, 0);
      else if (c == 8)           chk("t3_sqrt_ready", in_ready, 1);
      if (c == 3 || c == 8 || c == 16) begin
        chk("t3_wb_valid", wb_valid, 1);
        chk("t3_wb_rd", wb_rd, (c == 3) ? 6 : (c == 8) ? 4 : 5);
      end else begin
        chk("t3_wb_quiet", wb_valid, 0);
      end
      step();
    end
    $display("seq div/sqrt/mul done");

    // Flush drops in-flight ops but a result due in the flush cycle still shows
    drive(7'h08, 3'd0, 5'd7, 1'b1); #3;
    chk("t6_mul_accept", fpu_valid, 1); step();
    flush = 1'b1; drive(7'h00, 3'd0, 5'd8, 1'b1); #3;
    chk("t6_flush_ready", in_ready, 0);
    chk("t6_flush_no_launch", fpu_valid, 0);
    chk("t6_flush_busy", busy, 1); step();
    flush = 1'b0; in_valid = 1'b0; #3;
    chk("t6_after_wb", wb_valid, 0);
    chk("t6_after_busy", busy, 0); step();
    drive(7'h00, 3'd0, 5'd9, 1'b1); step();
    in_valid = 1'b0; step();
    flush = 1'b1; #3;
    chk("t6_due_in_flush", wb_valid, 1);
    chk("t6_due_rd", wb_rd, 9); step();
    flush = 1'b0; #3;
    chk("t6_post_flush", wb_valid, 0); step();
    $display("seq flush done");

    // Asynchronous reset with a divide in flight
    drive(7'h0C, 3'd0, 5'd4, 1'b1); step();
    in_valid = 1'b0; step(); step();
    rstn = 1'b0; #3;
    chk("rst_mid_wb", wb_valid, 0);
    chk("rst_mid_busy", busy, 0); step(); step();
    rstn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #3; chk("rst_no_stale_wb", wb_valid, 0); step();
    end
    #3; chk("rst_ready_after", in_ready, 1); step();
    $display("seq reset mid-op done");

    // Random traffic against the due-cycle scoreboard
    t = 0; div_free = 0;
    for (int k = 0; k < 3000; k++) begin
      flush = ($urandom_range(0, 19) == 0);
      drive(f7list[$urandom_range(0, 8)], 3'($urandom_range(0, 3)),
            5'($urandom_range(0, 31)), ($urandom_range(0, 9) < 7));
      ref_decode(funct7, funct3, ectl, elat, eill, edv);
      if (flush)     eready = 1'b0;
      else if (eill) eready = 1'b1;
      else begin
        eready = !(edv && t < div_free);
        foreach (pq[j]) if (pq[j].due == t + elat) eready = 1'b0;
      end
      eacc = in_valid && eready;
      exp_wb = 0; exp_rd = '0;
      ebusy = (t < div_free);
      foreach (pq[j]) begin
        if (pq[j].due >= t) ebusy = 1'b1;
        if (pq[j].due == t) begin exp_wb++; exp_rd = pq[j].rd; end
      end
      #3;
      chk("rnd_ready", in_ready, eready);
      chk("rnd_fpu_valid", fpu_valid, eacc);
      chk("rnd_ctl", fpucontrol, ectl);
      chk("rnd_illegal", illegal, eacc && eill);
      chk("rnd_wb_valid", wb_valid, (exp_wb != 0));
      if (exp_wb != 0) chk("rnd_wb_rd", wb_rd, exp_rd);
      chk("rnd_busy", busy, ebusy);
      for (int j = pq.size() - 1; j >= 0; j--)
        if (pq[j].due <= t || flush) pq.delete(j);
      if (flush && div_free > t + 1) div_free = t + 1;
      if (eacc && !eill) begin
        pq.push_back('{t + elat, rd});
        if (edv) div_free = t + 8;
      end
      if (k % 300 == 0)
        $display("rnd cyc=%0d f7=%h acc=%0b wb=%0b pending=%0d", t, funct7, eacc, wb_valid, pq.size());
      step();
      t++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
